pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 23 ++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage FSM encoding, default payload widths
// and the occupancy mapping.
package pipe_stage_reg_pkg;

  localparam int unsigned DEF_DATA_W = 175;
  localparam int unsigned DEF_CTRL_W = 10;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } stage_state_e;

  function automatic logic [1:0] occ_of(input stage_state_e s);
    case (s)
      ST_EMPTY: return 2'd0;
      ST_ONE:   return 2'd1;
      default:  return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with registered in_ready,
// flush, bubble-clean control and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = pipe_stage_reg_pkg::DEF_DATA_W,
  parameter int unsigned CTRL_W     = pipe_stage_reg_pkg::DEF_CTRL_W,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = pipe_stage_reg_pkg::DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  import pipe_stage_reg_pkg::*;

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, drain, valid_w;

  assign valid_w = (state_q != ST_EMPTY);
  assign accept  = in_valid & in_ready_q;
  assign drain   = valid_w & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    skid_ctrl_d = skid_ctrl_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_TWO;
          end else if (drain) begin
            // Bubble must carry no write/branch enables once the stage empties.
            main_ctrl_d = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  // Registered ready: derived from the next state, so it never follows out_ready.
  assign in_ready_d = (state_d != ST_TWO);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_w && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Data registers only join the reset net when they must be cleared.
  if (CLEAR_DATA) begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end else begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
      end
    end
  end else begin : g_data_hold
    always_ff @(posedge clk) begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = valid_w;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_of(state_q);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg against a queue scoreboard.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 175;
  localparam int unsigned CW = 10;
  localparam int unsigned SW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  item_t         q[$];
  logic          exp_rdy = 1'b0;
  logic [SW-1:0] m_stall = '0;
  logic          m_data_zero = 1'b1;
  int            nerr = 0;
  int            nchk = 0;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CLEAR_DATA(1'b1),
    .CNT_W(SW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic ordy, input logic fl);
    logic ov, acc, drn;
    @(negedge clk);
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
    #1;
    ov = (q.size() != 0);
    check("occupancy", 192'(occupancy), 192'(q.size()));
    check("in_ready", 192'(in_ready), 192'(exp_rdy));
    check("out_valid", 192'(out_valid), 192'(ov));
    check("stall_cnt", 192'(stall_cnt), 192'(m_stall));
    if (ov) begin
      check("out_ctrl", 192'(out_ctrl), 192'(q[0].c));
      check("out_data", 192'(out_data), 192'(q[0].d));
    end else begin
      check("bubble_ctrl", 192'(out_ctrl), 192'(0));
      if (m_data_zero) check("cleared_data", 192'(out_data), 192'(0));
    end
    acc = iv && exp_rdy;
    drn = ov && ordy;
    if (ov && !ordy && (m_stall != '1)) m_stall = m_stall + 1'b1;
    if (drn) void'(q.pop_front());
    if (fl) begin
      q.delete();
      m_data_zero = 1'b1;
    end else if (acc) begin
      q.push_back('{c: ic, d: id});
      m_data_zero = 1'b0;
    end
    exp_rdy = (q.size() != 2);
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_occ"}, 192'(occupancy), 192'(0));
    check({tag, "_in_ready"}, 192'(in_ready), 192'(0));
    check({tag, "_out_valid"}, 192'(out_valid), 192'(0));
    check({tag, "_out_ctrl"}, 192'(out_ctrl), 192'(0));
    check({tag, "_out_data"}, 192'(out_data), 192'(0));
    check({tag, "_stall"}, 192'(stall_cnt), 192'(0));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check_reset_outputs(tag);
    q.delete();
    m_stall = '0;
    m_data_zero = 1'b1;
    exp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_rdy_low_after_release"}, 192'(in_ready), 192'(0));
    @(posedge clk);
    #1;
    check({tag, "_rdy_first_edge"}, 192'(in_ready), 192'(1));
    exp_rdy = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    int pushed;
    int guard;
    logic iv, ordy, fl;
    logic [CW-1:0] rc;
    logic [DW-1:0] rd;

    do_reset("rst0");

    // Single transfer with downstream ready.
    step(1'b1, 10'h3FF, DW'(8'hA5), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Back-pressure fills both entries; third payload held off.
    step(1'b1, 10'd1, DW'(1), 1'b0, 1'b0);
    step(1'b1, 10'd2, DW'(2), 1'b0, 1'b0);
    step(1'b1, 10'd3, DW'(3), 1'b0, 1'b0);
    check("bp_occ_two", 192'(occupancy), 192'(2));
    check("bp_ready_low", 192'(in_ready), 192'(0));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush from occupancy 2 with a same-cycle offer.
    step(1'b1, 10'h155, DW'(16'hBEEF), 1'b0, 1'b0);
    step(1'b1, 10'h2AA, DW'(16'hCAFE), 1'b0, 1'b0);
    step(1'b1, 10'h0F0, DW'(16'h1234), 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("flush_occ", 192'(occupancy), 192'(0));
    check("flush_data", 192'(out_data), 192'(0));

    // Saturating stall counter with a 4-bit width.
    do_reset("rst1");
    step(1'b1, 10'h011, DW'(16'h7777), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("stall_sat", 192'(stall_cnt), 192'(15));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    pushed = 0;
    guard = 0;
    while (pushed < 10000 && guard < 60000) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 99) == 0);
      rc   = CW'($urandom);
      rd   = rnd_data();
      if (iv && exp_rdy && !fl) pushed++;
      step(iv, rc, rd, ordy, fl);
      guard++;
    end
    check("rand_budget", 192'(pushed), 192'(10000));
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while full.
    step(1'b1, 10'h101, DW'(16'hAAAA), 1'b0, 1'b0);
    step(1'b1, 10'h202, DW'(16'h5555), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    do_reset("async");
    step(1'b0, '0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
